// File: rtl/caravel_mprj_bram.sv
`default_nettype none
// ============================================================================
// caravel_mprj_bram: Wishbone BRAM slave, every access acked after DELAY waits
// Rev 1.0
// ============================================================================
module caravel_mprj_bram #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned DELAY     = 10
) (
  input  logic        wb_clk_i,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int unsigned AW   = $clog2(WORDS * 4);
  localparam int unsigned IW   = AW - 2;
  localparam logic [7:0]  LAST = 8'(DELAY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          hit;
  logic          fire;
  logic [IW-1:0] idx;
  logic [31:0]   mem [WORDS];
  logic          unused_adr_lsb;

  assign hit            = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:AW] == ADDR_BASE[31:AW]);
  assign idx            = wbs_adr_i[AW-1:2];
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // ACK goes straight back to counting when the bus still requests, so a
  // continuously held request is served every DELAY+1 cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (hit) state_nx = WAIT;
      end
      WAIT: begin
        if (!hit) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          fire     = 1'b1;
          state_nx = ACK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = 8'(cnt + 8'd1);
        end
      end
      ACK: begin
        cnt_nx   = '0;
        state_nx = hit ? WAIT : IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wbs_ack_o <= fire;
      if (fire && !wbs_we_i) wbs_dat_o <= mem[idx];
    end
  end

  // Storage has no reset so contents survive resetb.
  always_ff @(posedge wb_clk_i) begin
    if (fire && wbs_we_i && resetb) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) mem[idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_caravel_mprj_bram.sv
`default_nettype none
// Bench for caravel_mprj_bram: directed cases plus random traffic against a
// transaction-level model of the slave.
module tb_caravel_mprj_bram;

  localparam logic [31:0] BASE  = 32'h3800_0000;
  localparam int          WORDS = 1024;
  localparam int          DELAY = 10;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic        ack;
  logic [31:0] dat_o;

  caravel_mprj_bram #(.ADDR_BASE(BASE), .WORDS(WORDS), .DELAY(DELAY)) dut (
    .wb_clk_i (clk),
    .resetb   (resetb),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  // Model: an access starts on the first edge seeing a hit and completes
  // DELAY edges later if the hit never dropped in between.
  logic [31:0] m_mem   [WORDS];
  logic [3:0]  m_known [WORDS];
  int          m_start = -1;
  logic        m_ack = 1'b0;
  logic [31:0] m_rd = 32'h0;
  logic [3:0]  m_rd_known = 4'hF;

  function automatic bit in_window(input logic [31:0] a);
    longint aa;
    aa = longint'(a);
    return (aa >= longint'(BASE)) && (aa < longint'(BASE) + longint'(WORDS) * 4);
  endfunction

  task automatic step_model();
    bit h;
    int idx;
    h = cyc && stb && in_window(adr);
    idx = int'((adr - BASE) >> 2);
    if (!resetb) begin
      m_start = -1; m_ack = 1'b0; m_rd = 32'h0; m_rd_known = 4'hF;
    end else begin
      m_ack = 1'b0;
      if (!h) m_start = -1;
      else if (m_start < 0) m_start = edge_no;
      else if (edge_no - m_start == DELAY) begin
        m_ack = 1'b1;
        m_start = -1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) begin
              m_mem[idx][8*b +: 8] = dat_i[8*b +: 8];
              m_known[idx][b] = 1'b1;
            end
        end else begin
          m_rd = m_mem[idx];
          m_rd_known = m_known[idx];
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) m_known[i] = 4'h0;
    forever begin
      @(posedge clk);
      edge_no++;
      step_model();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    logic        exp_ack;
    logic [31:0] exp_dat, mask;
    forever begin
      @(negedge clk);
      exp_ack = resetb ? m_ack : 1'b0;
      exp_dat = resetb ? m_rd : 32'h0;
      mask = 32'h0;
      for (int b = 0; b < 4; b++)
        if (!resetb || m_rd_known[b]) mask[8*b +: 8] = 8'hFF;
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL model_ack edge=%0d actual=%0b required=%0b", edge_no, ack, exp_ack);
      end
      checks++;
      if ((dat_o & mask) !== (exp_dat & mask)) begin
        failures++;
        $display("FAIL model_dat edge=%0d actual=%h required=%h mask=%h", edge_no, dat_o, exp_dat, mask);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it for up to max_cyc edges; on ack, also
  // passes the master's sampling edge and leaves the bus driven.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int max_cyc,
                        output bit got, output int ack_edge, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    got = 1'b0; ack_edge = -1; rd = 32'h0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        ack_edge = edge_no + 1;
        rd = dat_o;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #600000;
    failures++;
    $display("FAIL timeout edge=%0d actual=running required=finished", edge_no);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit          got;
    int          ae, t0, prev, n;
    logic [31:0] rd, a;
    int          r, mx;

    resetb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_dat", dat_o, 32'h0);
    resetb = 1'b1;
    n = 0;
    repeat (5) begin @(posedge clk); #1; if (ack) n++; end
    check("idle_no_ack", 32'(n), 32'h0);

    t0 = edge_no + 1;
    access(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 30, got, ae, rd);
    check("wr_ack", 32'(got), 32'h1);
    check("wr_latency", 32'(ae - t0), 32'd11);
    idle(2);
    t0 = edge_no + 1;
    access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 30, got, ae, rd);
    check("rd_latency", 32'(ae - t0), 32'd11);
    check("rd_data", rd, 32'hDEAD_BEEF);
    idle(2);

    access(1'b1, BASE, 32'h1122_3344, 4'hF, 30, got, ae, rd);
    idle(1);
    access(1'b1, BASE, 32'hAABB_CCDD, 4'b0101, 30, got, ae, rd);
    idle(1);
    access(1'b0, BASE, 32'h0, 4'hF, 30, got, ae, rd);
    check("byte_en_data", rd, 32'h11BB_33DD);
    idle(2);

    access(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, 50, got, ae, rd);
    check("oow_lo_no_ack", 32'(got), 32'h0);
    idle(1);
    access(1'b1, 32'h3800_1000, 32'hFFFF_FFFF, 4'hF, 50, got, ae, rd);
    check("oow_hi_no_ack", 32'(got), 32'h0);
    idle(1);
    access(1'b0, 32'h3800_1000, 32'h0, 4'hF, 50, got, ae, rd);
    check("oow_rd_no_ack", 32'(got), 32'h0);
    idle(1);
    access(1'b0, BASE, 32'h0, 4'hF, 30, got, ae, rd);
    check("oow_unchanged", rd, 32'h11BB_33DD);
    idle(2);

    access(1'b1, BASE + 32'h20, 32'h0123_4567, 4'hF, 30, got, ae, rd);
    idle(2);
    access(1'b1, BASE + 32'h20, 32'hFFFF_0000, 4'hF, 5, got, ae, rd);
    check("abort_no_ack", 32'(got), 32'h0);
    n = 0;
    cyc = 1'b0; stb = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (ack) n++; end
    check("abort_quiet", 32'(n), 32'h0);
    access(1'b0, BASE + 32'h20, 32'h0, 4'hF, 30, got, ae, rd);
    check("abort_unchanged", rd, 32'h0123_4567);
    idle(2);

    access(1'b1, BASE + 32'h20, 32'h5555_AAAA, 4'hF, 7, got, ae, rd);
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(ack), 32'h0);
    idle(0);
    resetb = 1'b1;
    idle(2);
    check("rst_mid_dat_cleared", dat_o, 32'h0);
    access(1'b0, BASE + 32'h20, 32'h0, 4'hF, 30, got, ae, rd);
    check("rst_mid_unchanged", rd, 32'h0123_4567);
    idle(2);

    access(1'b1, BASE + 32'h20, 32'h7777_7777, 4'hF, DELAY, got, ae, rd);
    check("rst_edge_no_ack_yet", 32'(got), 32'h0);
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(0);
    resetb = 1'b1;
    idle(2);
    access(1'b0, BASE + 32'h20, 32'h0, 4'hF, 30, got, ae, rd);
    check("rst_edge_unchanged", rd, 32'h0123_4567);
    idle(2);

    prev = -1;
    for (int i = 0; i < 64; i++) begin
      access(1'b1, BASE + 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0101, 4'hF, 30, got, ae, rd);
      check("ramp_wr_ack", 32'(got), 32'h1);
      if (i > 0) check("ramp_wr_spacing", 32'(ae - prev), 32'(DELAY + 1));
      prev = ae;
    end
    for (int i = 0; i < 64; i++) begin
      access(1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, 30, got, ae, rd);
      check("ramp_rd_spacing", 32'(ae - prev), 32'(DELAY + 1));
      check("ramp_rd_data", rd, 32'h1000_0000 + 32'(i) * 32'h0101);
      prev = ae;
    end

    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 2);
      if (n > 0) idle(n);
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = 32'h3800_1000 + ($urandom & 32'h0000_0FFC);
      else a = $urandom & 32'h37FF_FFFF;
      mx = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DELAY) : DELAY + 3;
      access(1'($urandom), a, $urandom, 4'($urandom), mx, got, ae, rd);
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
